pcie_tlp_sva: RTL and testbench

Protocol checker for the simplified PCIe TLP request/completion channel. It sits passively beside any TLP producer/consumer pair on one clock domain and watches the valid/ready handshake and the accepted TLP header fields. It reports rule violations through sticky error flags, an error counter and concurrent assertions. It also tracks outstanding read tags so that completions can be matched to reads.

---
 rtl/pcie_tlp_pkg.sv | 39 +++
 rtl/pcie_tag_tracker.sv | 38 +++
 rtl/pcie_tlp_sva.sv | 84 ++++++++
 tb/tb_pcie_tlp_sva.sv | 136 +++++++++++++
 4 files changed

// File: rtl/pcie_tlp_pkg.sv
// pcie_tlp_pkg: shared TLP encodings, error-bit indices and rule names for the TLP checker
package pcie_tlp_pkg;
    localparam logic [2:0] TLP_MEMRD = 3'd0;
    localparam logic [2:0] TLP_MEMWR = 3'd1;
    localparam logic [2:0] TLP_CPL   = 3'd2;
    localparam logic [2:0] TLP_CPLD  = 3'd3;

    localparam logic [1:0] CPL_SC  = 2'd0;
    localparam logic [1:0] CPL_UR  = 2'd1;
    localparam logic [1:0] CPL_CRS = 2'd2;
    localparam logic [1:0] CPL_CA  = 2'd3;

    localparam int E_HOLD        = 0;
    localparam int E_STABLE      = 1;
    localparam int E_TYPE        = 2;
    localparam int E_ALIGN       = 3;
    localparam int E_LEN         = 4;
    localparam int E_BOUNDARY    = 5;
    localparam int E_STATUS      = 6;
    localparam int E_CPLD_STATUS = 7;
    localparam int N_RULES       = 8;

    typedef enum logic [2:0] {
        R_HOLD, R_STABLE, R_TYPE, R_ALIGN, R_LEN, R_BOUNDARY, R_STATUS, R_CPLD_STATUS
    } rule_e;

    function automatic string rule_name(input int i);
        case (rule_e'(i))
            R_HOLD:     return "HOLD";
            R_STABLE:   return "STABLE";
            R_TYPE:     return "TYPE";
            R_ALIGN:    return "ALIGN";
            R_LEN:      return "LEN";
            R_BOUNDARY: return "BOUNDARY";
            R_STATUS:   return "STATUS";
            default:    return "CPLD_STATUS";
        endcase
    endfunction
endpackage

// File: rtl/pcie_tag_tracker.sv
// pcie_tag_tracker: outstanding read tag table, outstanding count and unexpected-completion pulse
module pcie_tag_tracker
    import pcie_tlp_pkg::*;
#(
    parameter int TAG_W = 8
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             rd_hs,
    input  logic             cpl_hs,
    input  logic [TAG_W-1:0] tag,
    output logic [TAG_W:0]   outst_cnt,
    output logic             cpl_unexp
);
    logic [2**TAG_W-1:0] tags;
    logic                hit;

    assign hit = tags[tag];

    // reads set their tag, matching completions clear it; count tracks real bit transitions only
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            tags      <= '0;
            outst_cnt <= '0;
            cpl_unexp <= 1'b0;
        end else begin
            cpl_unexp <= cpl_hs && !hit;
            if (rd_hs)
                tags[tag] <= 1'b1;
            else if (cpl_hs && hit)
                tags[tag] <= 1'b0;
            if (rd_hs && !hit)
                outst_cnt <= outst_cnt + (TAG_W+1)'(1);
            else if (cpl_hs && hit)
                outst_cnt <= outst_cnt - (TAG_W+1)'(1);
        end
    end
endmodule

// File: rtl/pcie_tlp_sva.sv
// pcie_tlp_sva: passive PCIe TLP channel checker with sticky flags, counter and assertions
module pcie_tlp_sva
    import pcie_tlp_pkg::*;
#(
    parameter int ADDR_W = 32,
    parameter int LEN_W  = 10,
    parameter int TAG_W  = 8,
    parameter bit SVA_ON = 1'b1
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              tlp_valid,
    input  logic              tlp_ready,
    input  logic [2:0]        tlp_type,
    input  logic [ADDR_W-1:0] tlp_addr,
    input  logic [LEN_W-1:0]  tlp_len_dw,
    input  logic [TAG_W-1:0]  tlp_tag,
    input  logic [1:0]        cpl_status,
    output logic [7:0]        err_flags,
    output logic              err_any,
    output logic [15:0]       err_count,
    output logic [TAG_W:0]    outst_cnt,
    output logic              cpl_unexp
);
    localparam int SW = (LEN_W > 10 ? LEN_W : 10) + 1;
    localparam int FW = 3 + ADDR_W + LEN_W + TAG_W + 2;

    logic          vx, hs, stall_q, is_req;
    logic [FW-1:0] fld, fld_q;
    logic [SW-1:0] span;
    logic [7:0]    viol;
    logic [16:0]   cnt_nxt;

    assign fld     = {tlp_type, tlp_addr, tlp_len_dw, tlp_tag, cpl_status};
    assign err_any = |err_flags;

    // evaluate every rule for this edge; an X on valid counts as a hold violation and masks the rest
    always_comb begin
        vx                  = $isunknown(tlp_valid);
        hs                  = !vx && tlp_valid && tlp_ready;
        is_req              = tlp_type == TLP_MEMRD || tlp_type == TLP_MEMWR;
        span                = SW'(tlp_addr[11:2]) + SW'(tlp_len_dw);
        viol                = '0;
        viol[E_HOLD]        = vx || (stall_q && !tlp_valid);
        viol[E_STABLE]      = !vx && tlp_valid && stall_q && fld != fld_q;
        viol[E_TYPE]        = hs && tlp_type > TLP_CPLD;
        viol[E_ALIGN]       = hs && is_req && tlp_addr[1:0] != 2'd0;
        viol[E_LEN]         = hs && (tlp_type == TLP_CPL ? tlp_len_dw != '0 : (tlp_type <= TLP_CPLD && tlp_len_dw == '0));
        viol[E_BOUNDARY]    = hs && is_req && span > SW'(1024);
        viol[E_STATUS]      = hs && is_req && cpl_status != CPL_SC;
        viol[E_CPLD_STATUS] = hs && tlp_type == TLP_CPLD && cpl_status != CPL_SC;
        cnt_nxt             = {1'b0, err_count} + 17'($countones(viol));
    end

    // handshake history plus sticky flags and saturating violation count
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            stall_q   <= 1'b0;
            fld_q     <= '0;
            err_flags <= '0;
            err_count <= '0;
        end else begin
            stall_q   <= !vx && tlp_valid && !tlp_ready;
            fld_q     <= fld;
            err_flags <= err_flags | viol;
            err_count <= cnt_nxt[16] ? 16'hFFFF : cnt_nxt[15:0];
        end
    end

    pcie_tag_tracker #(.TAG_W(TAG_W)) u_tags (
        .clk       (clk),
        .rst       (rst),
        .rd_hs     (hs && tlp_type == TLP_MEMRD),
        .cpl_hs    (hs && (tlp_type == TLP_CPL || tlp_type == TLP_CPLD)),
        .tag       (tlp_tag),
        .outst_cnt (outst_cnt),
        .cpl_unexp (cpl_unexp)
    );

    for (genvar k = 0; k < N_RULES; k++) begin : g_sva
        a_rule: assert property (@(posedge clk) disable iff (rst || !SVA_ON) !viol[k])
            else $error("pcie_tlp_sva: rule %s violated", rule_name(k));
    end
endmodule

// File: tb/tb_pcie_tlp_sva.sv
// tb_pcie_tlp_sva: table-driven directed check of the TLP protocol checker
module tb_pcie_tlp_sva;
    logic        clk = 1'b0, rst = 1'b0;
    logic        tlp_valid = 1'b0, tlp_ready = 1'b0;
    logic [2:0]  tlp_type = '0;
    logic [31:0] tlp_addr = '0;
    logic [9:0]  tlp_len_dw = '0;
    logic [7:0]  tlp_tag = '0;
    logic [1:0]  cpl_status = '0;
    logic [7:0]  err_flags;
    logic        err_any;
    logic [15:0] err_count;
    logic [8:0]  outst_cnt;
    logic        cpl_unexp;
    int          total = 0, bad = 0;

    typedef struct {
        logic        rs, v, r;
        logic [2:0]  ty;
        logic [31:0] a;
        logic [9:0]  l;
        logic [7:0]  tg;
        logic [1:0]  s;
        logic [7:0]  f;
        logic [15:0] c;
        logic [8:0]  o;
        logic        u;
    } vec_t;

    vec_t tv[$];

    pcie_tlp_sva #(.ADDR_W(32), .LEN_W(10), .TAG_W(8), .SVA_ON(1'b0)) dut (
        .clk        (clk),
        .rst        (rst),
        .tlp_valid  (tlp_valid),
        .tlp_ready  (tlp_ready),
        .tlp_type   (tlp_type),
        .tlp_addr   (tlp_addr),
        .tlp_len_dw (tlp_len_dw),
        .tlp_tag    (tlp_tag),
        .cpl_status (cpl_status),
        .err_flags  (err_flags),
        .err_any    (err_any),
        .err_count  (err_count),
        .outst_cnt  (outst_cnt),
        .cpl_unexp  (cpl_unexp)
    );

    always #5 clk = ~clk;

    function automatic vec_t mk(input logic rs, v, r, input logic [2:0] ty, input logic [31:0] a,
                                input logic [9:0] l, input logic [7:0] tg, input logic [1:0] s,
                                input logic [7:0] f, input logic [15:0] c, input logic [8:0] o, input logic u);
        vec_t x;
        x.rs = rs; x.v = v; x.r = r; x.ty = ty; x.a = a; x.l = l; x.tg = tg; x.s = s;
        x.f = f; x.c = c; x.o = o; x.u = u;
        return x;
    endfunction

    task automatic check(input string n, input logic [31:0] act, input logic [31:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s: got %0h expected %0h at %0t", n, act, exp, $time);
        end
    endtask

    task automatic check_all(input string n, input logic [7:0] f, input logic [15:0] c, input logic [8:0] o, input logic u);
        check({n, " flags"}, 32'(err_flags), 32'(f));
        check({n, " any"}, 32'(err_any), 32'(|f));
        check({n, " count"}, 32'(err_count), 32'(c));
        check({n, " outst"}, 32'(outst_cnt), 32'(o));
        check({n, " unexp"}, 32'(cpl_unexp), 32'(u));
    endtask

    task automatic drive(input vec_t x);
        rst = x.rs; tlp_valid = x.v; tlp_ready = x.r; tlp_type = x.ty; tlp_addr = x.a;
        tlp_len_dw = x.l; tlp_tag = x.tg; cpl_status = x.s;
    endtask

    initial begin
        //           rs v  r  ty  addr       len tag  st  flags  cnt o  u
        tv.push_back(mk(0, 1, 1, 1, 32'h1000, 4, 8'h01, 0, 8'h00, 0, 0, 0));
        tv.push_back(mk(0, 1, 1, 0, 32'h2000, 2, 8'h02, 0, 8'h00, 0, 1, 0));
        tv.push_back(mk(0, 0, 0, 0, 32'h0,    0, 8'h00, 0, 8'h00, 0, 1, 0));
        tv.push_back(mk(0, 1, 1, 3, 32'h0,    2, 8'h02, 0, 8'h00, 0, 0, 0));
        tv.push_back(mk(0, 1, 1, 3, 32'h0,    2, 8'h02, 0, 8'h00, 0, 0, 1));
        tv.push_back(mk(0, 0, 0, 0, 32'h0,    0, 8'h00, 0, 8'h00, 0, 0, 0));
        tv.push_back(mk(0, 1, 1, 2, 32'h0,    0, 8'h03, 0, 8'h00, 0, 0, 1));
        tv.push_back(mk(0, 1, 1, 2, 32'h0,    1, 8'h03, 0, 8'h10, 1, 0, 1));
        tv.push_back(mk(0, 0, 0, 0, 32'h0,    0, 8'h00, 0, 8'h10, 1, 0, 0));
        tv.push_back(mk(0, 1, 1, 0, 32'h0FFC, 2, 8'h05, 0, 8'h30, 2, 1, 0));
        tv.push_back(mk(0, 1, 1, 1, 32'h1002, 1, 8'h01, 0, 8'h38, 3, 1, 0));
        tv.push_back(mk(0, 1, 1, 0, 32'h0FFE, 0, 8'h09, 2, 8'h78, 6, 2, 0));
        tv.push_back(mk(0, 1, 1, 3, 32'h0,    1, 8'h05, 3, 8'hF8, 7, 1, 0));
        tv.push_back(mk(1, 0, 0, 0, 32'h0,    0, 8'h00, 0, 8'h00, 0, 0, 0));
        tv.push_back(mk(0, 0, 0, 0, 32'h0,    0, 8'h00, 0, 8'h00, 0, 0, 0));
        tv.push_back(mk(0, 1, 0, 1, 32'h100,  1, 8'h07, 0, 8'h00, 0, 0, 0));
        tv.push_back(mk(0, 1, 0, 1, 32'h100,  1, 8'h07, 0, 8'h00, 0, 0, 0));
        tv.push_back(mk(0, 1, 0, 1, 32'h100,  1, 8'h07, 0, 8'h00, 0, 0, 0));
        tv.push_back(mk(0, 1, 0, 1, 32'h104,  1, 8'h07, 0, 8'h02, 1, 0, 0));
        tv.push_back(mk(0, 0, 0, 1, 32'h104,  1, 8'h07, 0, 8'h03, 2, 0, 0));
        tv.push_back(mk(0, 0, 0, 0, 32'h0,    0, 8'h00, 0, 8'h03, 2, 0, 0));
        tv.push_back(mk(1, 0, 0, 0, 32'h0,    0, 8'h00, 0, 8'h00, 0, 0, 0));
        tv.push_back(mk(0, 0, 0, 0, 32'h0,    0, 8'h00, 0, 8'h00, 0, 0, 0));
        tv.push_back(mk(0, 1, 1, 5, 32'h0,    1, 8'h00, 1, 8'h04, 1, 0, 0));
        tv.push_back(mk(0, 1, 0, 1, 32'h200,  1, 8'h00, 0, 8'h04, 1, 0, 0));

        #2 rst = 1'b1;
        #1 check_all("reset", 8'h00, 16'h0, 9'h0, 1'b0);
        @(negedge clk) rst = 1'b0;

        foreach (tv[i]) begin
            @(negedge clk) drive(tv[i]);
            @(posedge clk) #1;
            check_all($sformatf("vec%0d", i), tv[i].f, tv[i].c, tv[i].o, tv[i].u);
        end

        @(negedge clk) rst = 1'b1;
        #1 check_all("async reset", 8'h00, 16'h0, 9'h0, 1'b0);
        tlp_valid = 1'b0;
        #1 rst = 1'b0;
        @(posedge clk) #1;
        check_all("no hold after reset", 8'h00, 16'h0, 9'h0, 1'b0);

        @(negedge clk) drive(mk(0, 1, 1, 0, 32'h0FFE, 0, 8'h11, 1, 0, 0, 0, 0));
        repeat (21844) @(posedge clk);
        #1 check("sat pre", 32'(err_count), 32'd65532);
        @(posedge clk) #1 check("sat hit", 32'(err_count), 32'd65535);
        @(posedge clk) #1;
        check_all("sat hold", 8'h58, 16'hFFFF, 9'h1, 1'b0);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end
endmodule
